// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a show-ahead byte FIFO.
// Define UART_RX_PARITY_EN to add an even-parity bit and the sticky parity_err flag.
module uart_rx_fifo #(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 115200,
    parameter int FIFO_AW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    input  logic             rd_en,
    input  logic             clr_err,
    output logic [7:0]       rd_data,
    output logic             empty,
    output logic             full,
    output logic [FIFO_AW:0] count,
    output logic             frame_err,
    output logic             overflow,
`ifdef UART_RX_PARITY_EN
    output logic             parity_err,
`endif
    output logic [2:0]       dbg_state
);

    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int HALF  = DIV / 2;
    localparam int CW    = $clog2(DIV);
    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [CW-1:0]      DIV_M1   = CW'(DIV - 1);
    localparam logic [CW-1:0]      HALF_M1  = CW'(HALF - 1);
    localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
    localparam logic [FIFO_AW:0]   DEPTH_C  = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   COUNT_1  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t         state;
    logic           rx_meta;
    logic           rxs;
    logic [1:0]     sync_ok;
    logic           rxs_prev;
    logic [CW-1:0]  cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shreg;
    logic           push_req;
    logic [7:0]     push_data;
    logic           fall;
    logic           stop_tick;
    logic           fe_set;

    // rxs_prev only takes the line value once rxs reflects a real sample, so a
    // line held low through reset release is not mistaken for a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            sync_ok  <= 2'b00;
            rxs_prev <= 1'b0;
        end else begin
            rx_meta  <= rx;
            rxs      <= rx_meta;
            sync_ok  <= {sync_ok[0], 1'b1};
            rxs_prev <= sync_ok[1] & rxs;
        end
    end

    assign fall      = rxs_prev & ~rxs;
    assign stop_tick = (state == S_STOP) && (cnt == DIV_M1);
    assign fe_set    = stop_tick & ~rxs;
    assign dbg_state = state;

`ifdef UART_RX_PARITY_EN
    logic par_bad;
    logic par_set;
    assign par_set = (state == S_PARITY) && (cnt == DIV_M1) && ((^shreg) ^ rxs);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            push_req  <= 1'b0;
            push_data <= '0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            push_req  <= 1'b0;
            frame_err <= fe_set | (frame_err & ~clr_err);
`ifdef UART_RX_PARITY_EN
            parity_err <= par_set | (parity_err & ~clr_err);
`endif
            case (state)
                S_IDLE: begin
                    if (fall) begin
                        state <= S_START;
                        cnt   <= '0;
                    end
                end
                S_START: begin
                    if (cnt == HALF_M1) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rxs ? S_IDLE : S_DATA;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (cnt == DIV_M1) begin
                        cnt     <= '0;
                        shreg   <= {rxs, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (cnt == DIV_M1) begin
                        cnt     <= '0;
                        par_bad <= (^shreg) ^ rxs;
                        state   <= S_STOP;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
`endif
                S_STOP: begin
                    if (cnt == DIV_M1) begin
                        cnt <= '0;
                        if (rxs) begin
`ifdef UART_RX_PARITY_EN
                            push_req <= ~par_bad;
`else
                            push_req <= 1'b1;
`endif
                            push_data <= shreg;
                            state     <= S_IDLE;
                        end else begin
                            state <= S_BREAK;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_BREAK: begin
                    if (rxs) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Pop handshake: rd_data is valid whenever empty=0; a cycle with rd_en=1
    // and empty=0 consumes the head, rd_en with empty=1 does nothing.
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic               do_pop;
    logic               do_push;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign do_pop  = rd_en & ~empty;
    assign do_push = push_req & (~full | do_pop);
    assign rd_data = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= (push_req & full & ~do_pop) | (overflow & ~clr_err);
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + COUNT_1;
                2'b01:   count <= count - COUNT_1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at DIV=16 with a 4-entry FIFO.
module tb_uart_rx_fifo;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rx = 1'b1;
    logic          rd_en = 1'b0;
    logic          clr_err = 1'b0;
    logic [7:0]    rd_data;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          frame_err;
    logic          overflow;
    logic [2:0]    dbg_state;
`ifdef UART_RX_PARITY_EN
    logic          parity_err;
`endif

    int total = 0;
    int bad = 0;
    logic empty_pre;
    logic empty_post;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        bit         pop;
        logic [AW:0] exp_count;
        bit         exp_full;
        bit         exp_ov;
        logic [7:0] exp_head;
    } vec_t;

    vec_t vecs [10];

    uart_rx_fifo #(.CLK_FREQ(16), .BAUD(1), .FIFO_AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rd_en     (rd_en),
        .clr_err   (clr_err),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .frame_err (frame_err),
        .overflow  (overflow),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One 8N1 frame; rx is left at the stop level on return.
    task automatic send_byte(input logic [7:0] d, input bit stop, input bit pop_at_push);
        @(negedge clk);
        rx = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (16) @(negedge clk);
            rx = d[i];
        end
        repeat (16) @(negedge clk);
        rx = stop;
        repeat (11) @(negedge clk);
        empty_pre = empty;
        if (pop_at_push) rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        empty_post = empty;
        repeat (4) @(negedge clk);
    endtask

    task automatic pop_one(input string name);
        logic [7:0] e;
        e = exp_q.pop_front();
        chk(name, rd_data, e);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int r = lo; r <= hi; r++) begin
            if (vecs[r].pop && exp_q.size() > 0) void'(exp_q.pop_front());
            if (exp_q.size() < 4) exp_q.push_back(vecs[r].data);
            send_byte(vecs[r].data, 1'b1, vecs[r].pop);
            chk($sformatf("row%0d_count", r), count, vecs[r].exp_count);
            chk($sformatf("row%0d_full", r), full, vecs[r].exp_full);
            chk($sformatf("row%0d_overflow", r), overflow, vecs[r].exp_ov);
            chk($sformatf("row%0d_head", r), rd_data, vecs[r].exp_head);
        end
    endtask

    initial begin
        vecs[0] = '{8'h01, 1'b0, 3'd1, 1'b0, 1'b0, 8'h01};
        vecs[1] = '{8'h02, 1'b0, 3'd2, 1'b0, 1'b0, 8'h01};
        vecs[2] = '{8'h03, 1'b0, 3'd3, 1'b0, 1'b0, 8'h01};
        vecs[3] = '{8'h04, 1'b0, 3'd4, 1'b1, 1'b0, 8'h01};
        vecs[4] = '{8'h05, 1'b0, 3'd4, 1'b1, 1'b1, 8'h01};
        vecs[5] = '{8'h10, 1'b0, 3'd1, 1'b0, 1'b0, 8'h10};
        vecs[6] = '{8'h11, 1'b0, 3'd2, 1'b0, 1'b0, 8'h10};
        vecs[7] = '{8'h12, 1'b0, 3'd3, 1'b0, 1'b0, 8'h10};
        vecs[8] = '{8'h13, 1'b0, 3'd4, 1'b1, 1'b0, 8'h10};
        vecs[9] = '{8'h14, 1'b1, 3'd4, 1'b1, 1'b0, 8'h11};

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_state", dbg_state, 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // basic receive and push latency
        send_byte(8'hA5, 1'b1, 1'b0);
        chk("basic_empty_at_stop_sample", empty_pre, 1);
        chk("basic_empty_next_cycle", empty_post, 0);
        chk("basic_rd_data", rd_data, 8'hA5);
        chk("basic_count", count, 1);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        chk("basic_pop_empty", empty, 1);
        chk("basic_pop_count", count, 0);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        chk("pop_on_empty_count", count, 0);
        chk("pop_on_empty_empty", empty, 1);

        // glitch rejection
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        chk("glitch_in_start", dbg_state, 1);
        @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch_state_idle", dbg_state, 0);
        chk("glitch_empty", empty, 1);
        chk("glitch_frame_err", frame_err, 0);
        chk("glitch_overflow", overflow, 0);

        // overflow with a 4-deep FIFO
        run_rows(0, 4);
        for (int i = 0; i < 4; i++) pop_one($sformatf("ovf_pop%0d", i));
        chk("ovf_drained", empty, 1);
        chk("ovf_still_sticky", overflow, 1);
        pulse_clr();
        chk("ovf_cleared", overflow, 0);

        // full FIFO with pop in the push cycle
        run_rows(5, 9);
        for (int i = 0; i < 4; i++) pop_one($sformatf("simul_pop%0d", i));
        chk("simul_drained", empty, 1);

        // framing error and recovery
        send_byte(8'h3C, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        chk("fe_state_break", dbg_state, 5);
        chk("fe_flag", frame_err, 1);
        chk("fe_nothing_pushed", count, 0);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        chk("fe_state_idle", dbg_state, 0);
        exp_q.push_back(8'h5A);
        send_byte(8'h5A, 1'b1, 1'b0);
        chk("fe_next_count", count, 1);
        pop_one("fe_next_data");
        chk("fe_still_sticky", frame_err, 1);
        pulse_clr();
        chk("fe_cleared", frame_err, 0);

        // reset in the middle of bit 3 of 0xFF, with a byte already buffered
        send_byte(8'h42, 1'b1, 1'b0);
        chk("pre_rst_count", count, 1);
        @(negedge clk);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (54) @(negedge clk);
        chk("pre_rst_state_data", dbg_state, 2);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_full", full, 0);
        chk("mid_rst_rd_data", rd_data, 0);
        chk("mid_rst_state", dbg_state, 0);
        chk("mid_rst_flags", {frame_err, overflow}, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (120) @(negedge clk);
        chk("post_rst_state", dbg_state, 0);
        chk("post_rst_empty", empty, 1);
        exp_q.push_back(8'h81);
        send_byte(8'h81, 1'b1, 1'b0);
        chk("post_rst_count", count, 1);
        chk("post_rst_flags", {frame_err, overflow}, 0);
        pop_one("post_rst_data");
        chk("post_rst_drained", empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
